// File: rtl/conv_encoder.sv
// 8-state recursive systematic convolutional encoder with a one-deep registered
// output stage and optional 3-symbol trellis termination.
module conv_encoder #(
   parameter bit TAIL_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_bit,
   input  logic in_last,
   output logic out_valid,
   input  logic out_ready,
   output logic sys,
   output logic parity,
   output logic out_tail,
   output logic out_last
);

   typedef enum logic {ENC, TAIL} state_e;

   state_e     state_q, state_d;
   logic [2:0] s_q, s_d;
   logic [1:0] tcnt_q, tcnt_d;
   logic       valid_q, valid_d;
   logic       sys_q, sys_d;
   logic       par_q, par_d;
   logic       tail_q, tail_d;
   logic       last_q, last_d;

   logic       free, load_enc, load_tail;
   logic       u, b, p;

   assign free      = !valid_q || out_ready;
   assign load_enc  = (state_q == ENC) && in_valid && free;
   assign load_tail = (state_q == TAIL) && free;

   // Tail input is chosen so the feedback bit is zero, flushing the register.
   assign u = (state_q == TAIL) ? (s_q[0] ^ s_q[2]) : in_bit;
   assign b = u ^ s_q[0] ^ s_q[2];
   assign p = b ^ s_q[1] ^ s_q[2];

   assign in_ready  = rst && (state_q == ENC) && free;
   assign out_valid = valid_q;
   assign sys       = sys_q;
   assign parity    = par_q;
   assign out_tail  = tail_q;
   assign out_last  = last_q;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      tcnt_d  = tcnt_q;
      valid_d = valid_q && !out_ready;
      sys_d   = sys_q;
      par_d   = par_q;
      tail_d  = tail_q;
      last_d  = last_q;
      if (load_enc) begin
         valid_d = 1'b1;
         sys_d   = u;
         par_d   = p;
         tail_d  = 1'b0;
         last_d  = in_last && !TAIL_EN;
         s_d     = {s_q[1:0], b};
         if (in_last) begin
            if (TAIL_EN) begin
               state_d = TAIL;
               tcnt_d  = 2'd0;
            end else begin
               s_d = '0;
            end
         end
      end else if (load_tail) begin
         valid_d = 1'b1;
         sys_d   = u;
         par_d   = p;
         tail_d  = 1'b1;
         last_d  = (tcnt_q == 2'd2);
         s_d     = {s_q[1:0], 1'b0};
         tcnt_d  = tcnt_q + 2'd1;
         if (tcnt_q == 2'd2) begin
            state_d = ENC;
            tcnt_d  = '0;
            s_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ENC;
         s_q     <= '0;
         tcnt_q  <= '0;
         valid_q <= 1'b0;
         sys_q   <= 1'b0;
         par_q   <= 1'b0;
         tail_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         tcnt_q  <= tcnt_d;
         valid_q <= valid_d;
         sys_q   <= sys_d;
         par_q   <= par_d;
         tail_q  <= tail_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter TAIL_EN, default 1, meaning 1 = append 3 termination symbols after in_last, 0 = no termination.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_bit/in_last valid.
REQ-005 in_ready  output  1  encoder accepts the input this cycle.
REQ-006 in_bit  input  1  information bit u.
REQ-007 in_last  input  1  marks the final information bit of a frame.
REQ-008 out_valid  output  1  sys/parity symbol valid.
REQ-009 out_ready  input  1  downstream (branch metric side) accepts the symbol.
REQ-010 sys  output  1  systematic bit.
REQ-011 parity  output  1  parity bit.
REQ-012 out_tail  output  1  current symbol is a termination symbol.
REQ-013 out_last  output  1  current symbol is the final symbol of the frame.

Function
REQ-014 Encoder shall be 8-state recursive systematic, with state register s[2:0], where s[0] is the newest bit.
- Per step: b = u^s[0]^s[2]; sys = u; parity = b^s[1]^s[2]; next s = {s[1:0], b}.
REQ-015 Resulting trellis shall match the decoder: 0->0:00, 0->1:11, 1->3:01, 1->2:10, 2->4:01, 2->5:10, 3->7:00, 3->6:11, 4->1:00, 4->0:11, 5->2:01, 5->3:10, 6->5:01, 6->4:10, 7->6:00, 7->7:11.
REQ-016 FSM shall have states ENC and TAIL; reset state is ENC with s=000.
REQ-017 Output shall be a single registered stage; in_ready = (fsm==ENC) && (!out_valid || out_ready).
REQ-018 Input handshake is in_valid && in_ready: register {sys, parity} for u=in_bit, update s, set out_valid=1.
- out_tail=0; out_last = in_last && !TAIL_EN.
REQ-019 Symbol transfer is out_valid && out_ready; sys/parity/out_tail/out_last shall hold stable while out_valid && !out_ready.
REQ-020 Transfer with no new load shall clear out_valid on the next edge; transfer and load in the same cycle shall keep out_valid=1 with the new symbol (zero-bubble throughput, 1 symbol/cycle).
REQ-021 Latency shall be 1 cycle from input handshake to out_valid.
REQ-022 On a handshake with in_last=1 and TAIL_EN=1, FSM shall go to TAIL and clear tail counter tcnt[1:0] to 0.
REQ-023 In TAIL, whenever the output stage is free (!out_valid || out_ready), encoder shall load a tail symbol and increment tcnt.
- Tail symbol: u = s[0]^s[2], so b = 0; sys = u; parity = s[1]^s[2]; out_tail=1.
REQ-024 Third tail symbol (tcnt==2) shall set out_last=1; FSM shall return to ENC with s=000 guaranteed.
REQ-025 in_valid shall be ignored in TAIL (in_ready=0).
REQ-026 With TAIL_EN=0, in_last shall produce out_last on that symbol, s shall reset to 000 after that load, and FSM shall remain in ENC.
REQ-027 in_valid without a handshake shall have no effect; in_bit/in_last shall be don't-care when in_valid=0.

Reset
REQ-028 While rst=0: s=000, FSM=ENC, tcnt=0, out_valid=0, sys=0, parity=0, out_tail=0, out_last=0, in_ready=0.
REQ-029 Reset asserted mid-frame or mid-tail shall abort immediately with no further symbols.
- First in_ready=1 shall occur in the first cycle after rst deasserts.

Verification
REQ-030 Reset, then bits 1,0,1,1 (last on 4th), out_ready=1 -> symbols 11,01,11,10, then tail 11,00,00 with out_tail=1 and out_last only on final 00; s ends at 000.
REQ-031 Same frame with out_ready low for 3 cycles after the 2nd symbol -> 01 held stable, in_ready=0, no symbol lost or duplicated, identical sequence.
REQ-032 Back-to-back frames with continuous in_valid -> in_ready=0 for exactly 3 cycles during tail; second frame starts from s=000.
REQ-033 Exhaustive single steps from each of the 8 states (reach via input prefixes) with u=0/1 -> all 16 transitions/outputs match REQ-015.
REQ-034 rst pulled low during 2nd tail symbol -> outputs 0 asynchronously; after release a new frame 1 -> 11.
REQ-035 TAIL_EN=0, frame 1,0 (last) -> 11,01 with out_last on 01; no tail; next frame starts at s=000.
